// File: rtl/calc_pkg.sv
// Shared constants and helpers for the calculator arithmetic sequencer.
// The optional remainder output is enabled with CALC_REM_EN.
package calc_pkg;

  localparam int OP_BITS   = 7;
  localparam int CONV_BITS = 14;

  localparam logic [3:0] OP_ADD = 4'hA;
  localparam logic [3:0] OP_SUB = 4'hB;
  localparam logic [3:0] OP_MUL = 4'hC;
  localparam logic [3:0] OP_DIV = 4'hD;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_JOIN = 3'd1;
  localparam logic [2:0] S_EXEC = 3'd2;
  localparam logic [2:0] S_CONV = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [2:0] EXEC_ADD    = 3'd1;
  localparam logic [2:0] EXEC_MULDIV = 3'd7;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd2_t;

  // Invalid digits produce a truncated value; callers flag them as errors anyway.
  function automatic logic [OP_BITS-1:0] join_bcd(input bcd2_t d);
    return {3'd0, d.tens} * 7'd10 + {3'd0, d.ones};
  endfunction

  function automatic logic digit_bad(input logic [3:0] d);
    return d > 4'd9;
  endfunction

endpackage

// File: rtl/calc_bin2bcd.sv
// Sequential shift-add-3 binary to BCD converter. The load cycle already
// performs the first shift, so a WIDTH-bit value finishes WIDTH-1 cycles later.
module calc_bin2bcd #(
  parameter int WIDTH  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  load,
  input  logic [WIDTH-1:0]      bin,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  done
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] sh_r;
  logic [BW-1:0]    bcd_r;
  logic [CW-1:0]    cnt_r;
  logic             run_r;
  logic             done_r;
  logic [BW-1:0]    adj_s;
  logic [BW-1:0]    step_s;

  // One double-dabble iteration: add 3 to every digit >= 5, then shift in the next bit.
  always_comb begin
    adj_s = bcd_r;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_r[4*i +: 4] >= 4'd5) begin
        adj_s[4*i +: 4] = bcd_r[4*i +: 4] + 4'd3;
      end else begin
        adj_s[4*i +: 4] = bcd_r[4*i +: 4];
      end
    end
    step_s = BW'({adj_s, sh_r[WIDTH-1]});
  end

  // Conversion sequencing; done stays high until the next load or clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_r   <= '0;
      bcd_r  <= '0;
      cnt_r  <= '0;
      run_r  <= 1'b0;
      done_r <= 1'b0;
    end else if (clr) begin
      sh_r   <= '0;
      bcd_r  <= '0;
      cnt_r  <= '0;
      run_r  <= 1'b0;
      done_r <= 1'b0;
    end else if (load) begin
      sh_r   <= bin << 1;
      bcd_r  <= {{(BW-1){1'b0}}, bin[WIDTH-1]};
      cnt_r  <= CW'(1);
      run_r  <= 1'b1;
      done_r <= 1'b0;
    end else if (run_r) begin
      sh_r  <= sh_r << 1;
      bcd_r <= step_s;
      cnt_r <= cnt_r + CW'(1);
      if (cnt_r == CW'(WIDTH - 1)) begin
        run_r  <= 1'b0;
        done_r <= 1'b1;
      end
    end
  end

  assign bcd  = bcd_r;
  assign done = done_r;

endmodule

// File: rtl/calc_alu_seq.sv
// Multi-cycle BCD calculator ALU: join digits, execute, convert back to BCD.
// Define CALC_REM_EN to add the BCD division remainder outputs.
module calc_alu_seq
  import calc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       clr,
  input  logic [3:0] op,
  input  logic [3:0] a_tens,
  input  logic [3:0] a_ones,
  input  logic [3:0] b_tens,
  input  logic [3:0] b_ones,
  output logic       busy,
  output logic       done,
  output logic [3:0] res_d3,
  output logic [3:0] res_d2,
  output logic [3:0] res_d1,
  output logic [3:0] res_d0,
  output logic       neg,
  output logic       err
`ifdef CALC_REM_EN
  ,
  output logic [3:0] rem_tens,
  output logic [3:0] rem_ones
`endif
);

  logic [2:0]           state_r, state_nx_s;
  logic [3:0]           op_r;
  bcd2_t                a_dig_r, b_dig_r;
  logic [OP_BITS-1:0]   a_r, b_r;
  logic [2:0]           exec_cnt_r;
  logic [CONV_BITS-1:0] prod_r, mcand_r;
  logic [OP_BITS-1:0]   mplier_r, dvd_r, rem_r;
  logic [OP_BITS-2:0]   quo_r;
  logic                 neg_pend_r;
  logic [15:0]          res_r;
  logic                 neg_r, err_r, busy_r, done_r;

  logic [OP_BITS-1:0]   a_join_s, b_join_s;
  logic                 join_err_s;
  logic                 exec_last_s;
  logic [2:0]           exec_len_s;
  logic [CONV_BITS-1:0] prod_nx_s;
  logic [OP_BITS:0]     trial_s;
  logic                 div_ge_s;
  logic [OP_BITS-1:0]   rem_nx_s;
  logic [OP_BITS-1:0]   quo_nx_s;
  logic [CONV_BITS-1:0] r_s;
  logic                 neg_s;
  logic                 conv_load_s;
  logic                 enter_done_s;
  logic [15:0]          res_bcd_s;
  logic                 res_ready_s;

  // Operand join and error detection on the latched digits.
  always_comb begin
    a_join_s   = join_bcd(a_dig_r);
    b_join_s   = join_bcd(b_dig_r);
    join_err_s = digit_bad(a_dig_r.tens) || digit_bad(a_dig_r.ones) ||
                 digit_bad(b_dig_r.tens) || digit_bad(b_dig_r.ones) ||
                 (op_r < OP_ADD) || (op_r > OP_DIV) ||
                 ((op_r == OP_DIV) && (b_join_s == 7'd0));
  end

  // Execute step: shift-add multiply, restoring divide, add/sub result select.
  always_comb begin
    prod_nx_s = prod_r + (mplier_r[0] ? mcand_r : 14'd0);
    trial_s   = {rem_r, dvd_r[OP_BITS-1]};
    div_ge_s  = trial_s >= {1'b0, b_r};
    if (div_ge_s) begin
      rem_nx_s = 7'(trial_s - {1'b0, b_r});
    end else begin
      rem_nx_s = trial_s[OP_BITS-1:0];
    end
    quo_nx_s   = {quo_r, div_ge_s};
    neg_s      = (op_r == OP_SUB) && (a_r < b_r);
    exec_len_s = ((op_r == OP_MUL) || (op_r == OP_DIV)) ? EXEC_MULDIV : EXEC_ADD;
    exec_last_s = (exec_cnt_r + 3'd1) == exec_len_s;
    case (op_r)
      OP_ADD:  r_s = {7'd0, a_r} + {7'd0, b_r};
      OP_SUB:  r_s = neg_s ? {7'd0, b_r - a_r} : {7'd0, a_r - b_r};
      OP_MUL:  r_s = prod_nx_s;
      OP_DIV:  r_s = {7'd0, quo_nx_s};
      default: r_s = 14'd0;
    endcase
  end

  // Next-state logic; clear forces IDLE from any state.
  always_comb begin
    state_nx_s  = state_r;
    conv_load_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) state_nx_s = S_JOIN;
        else       state_nx_s = S_IDLE;
      end
      S_JOIN: begin
        if (join_err_s) state_nx_s = S_DONE;
        else            state_nx_s = S_EXEC;
      end
      S_EXEC: begin
        if (exec_last_s) begin
          state_nx_s  = S_CONV;
          conv_load_s = !clr;
        end else begin
          state_nx_s = S_EXEC;
        end
      end
      S_CONV: begin
        if (res_ready_s) state_nx_s = S_DONE;
        else             state_nx_s = S_CONV;
      end
      S_DONE:  state_nx_s = S_IDLE;
      default: state_nx_s = S_IDLE;
    endcase
    if (clr) begin
      state_nx_s = S_IDLE;
    end else begin
      state_nx_s = state_nx_s;
    end
    enter_done_s = state_nx_s == S_DONE;
  end

  calc_bin2bcd #(.WIDTH(CONV_BITS), .DIGITS(4)) u_res_conv (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .load  (conv_load_s),
    .bin   (r_s),
    .bcd   (res_bcd_s),
    .done  (res_ready_s)
  );

`ifdef CALC_REM_EN
  logic [7:0] rem_bcd_s;
  logic       rem_ready_s;
  logic [7:0] rem_out_r;

  calc_bin2bcd #(.WIDTH(OP_BITS), .DIGITS(2)) u_rem_conv (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .load  (conv_load_s),
    .bin   ((op_r == OP_DIV) ? rem_nx_s : 7'd0),
    .bcd   (rem_bcd_s),
    .done  (rem_ready_s)
  );

  // Remainder digits load alongside the result and are zero unless a divide succeeded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_out_r <= 8'd0;
    end else if (clr) begin
      rem_out_r <= 8'd0;
    end else if ((state_r == S_JOIN) && join_err_s) begin
      rem_out_r <= 8'd0;
    end else if ((state_r == S_CONV) && res_ready_s) begin
      rem_out_r <= ((op_r == OP_DIV) && rem_ready_s) ? rem_bcd_s : 8'd0;
    end
  end

  assign rem_tens = rem_out_r[7:4];
  assign rem_ones = rem_out_r[3:0];
`endif

  // Control state, handshake and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      res_r   <= 16'd0;
      neg_r   <= 1'b0;
      err_r   <= 1'b0;
      op_r    <= 4'd0;
      a_dig_r <= '0;
      b_dig_r <= '0;
    end else if (clr) begin
      state_r <= S_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      res_r   <= 16'd0;
      neg_r   <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      done_r  <= enter_done_s;
      if ((state_r == S_IDLE) && start) begin
        busy_r  <= 1'b1;
        op_r    <= op;
        a_dig_r <= '{tens: a_tens, ones: a_ones};
        b_dig_r <= '{tens: b_tens, ones: b_ones};
      end else if (enter_done_s) begin
        busy_r <= 1'b0;
      end
      if ((state_r == S_JOIN) && join_err_s) begin
        res_r <= 16'd0;
        neg_r <= 1'b0;
        err_r <= 1'b1;
      end else if ((state_r == S_CONV) && res_ready_s) begin
        res_r <= res_bcd_s;
        neg_r <= neg_pend_r;
        err_r <= 1'b0;
      end
    end
  end

  // Arithmetic datapath: initialised in JOIN, stepped once per EXEC cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r        <= '0;
      b_r        <= '0;
      exec_cnt_r <= 3'd0;
      prod_r     <= '0;
      mcand_r    <= '0;
      mplier_r   <= '0;
      dvd_r      <= '0;
      rem_r      <= '0;
      quo_r      <= '0;
      neg_pend_r <= 1'b0;
    end else if (clr) begin
      exec_cnt_r <= 3'd0;
      neg_pend_r <= 1'b0;
    end else if (state_r == S_JOIN) begin
      a_r        <= a_join_s;
      b_r        <= b_join_s;
      exec_cnt_r <= 3'd0;
      prod_r     <= '0;
      mcand_r    <= {7'd0, a_join_s};
      mplier_r   <= b_join_s;
      dvd_r      <= a_join_s;
      rem_r      <= '0;
      quo_r      <= '0;
      neg_pend_r <= 1'b0;
    end else if (state_r == S_EXEC) begin
      exec_cnt_r <= exec_cnt_r + 3'd1;
      prod_r     <= prod_nx_s;
      mcand_r    <= mcand_r << 1;
      mplier_r   <= mplier_r >> 1;
      dvd_r      <= dvd_r << 1;
      rem_r      <= rem_nx_s;
      quo_r      <= quo_nx_s[OP_BITS-2:0];
      if (exec_last_s) neg_pend_r <= neg_s;
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign res_d3 = res_r[15:12];
  assign res_d2 = res_r[11:8];
  assign res_d1 = res_r[7:4];
  assign res_d0 = res_r[3:0];
  assign neg    = neg_r;
  assign err    = err_r;

endmodule

// File: tb/tb_calc_alu_seq.sv
// Directed vector bench for calc_alu_seq (remainder checks with CALC_REM_EN).
module tb_calc_alu_seq;
  import calc_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] op = 4'd0;
  logic [3:0] a_tens = 4'd0, a_ones = 4'd0, b_tens = 4'd0, b_ones = 4'd0;
  logic       busy, done, neg, err;
  logic [3:0] res_d3, res_d2, res_d1, res_d0;
`ifdef CALC_REM_EN
  logic [3:0] rem_tens, rem_ones;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  calc_alu_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clr(clr), .op(op),
    .a_tens(a_tens), .a_ones(a_ones), .b_tens(b_tens), .b_ones(b_ones),
    .busy(busy), .done(done),
    .res_d3(res_d3), .res_d2(res_d2), .res_d1(res_d1), .res_d0(res_d0),
    .neg(neg), .err(err)
`ifdef CALC_REM_EN
    , .rem_tens(rem_tens), .rem_ones(rem_ones)
`endif
  );

  typedef struct {
    logic [3:0]  op;
    logic [3:0]  at, ao, bt, bo;
    logic [15:0] res;
    logic        neg;
    logic        err;
    logic [7:0]  rem;
    int          lat;
  } vec_t;

  vec_t vecs[13];

  function automatic logic [15:0] res_val();
    return {res_d3, res_d2, res_d1, res_d0};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive_op(input logic [3:0] o, input logic [3:0] at, ao, bt, bo);
    op = o; a_tens = at; a_ones = ao; b_tens = bt; b_ones = bo;
  endtask

  // Issue one operation, measure latency and busy width, then check results.
  task automatic run_vec(input vec_t v, input string nm);
    int n;
    int bcnt;
    @(negedge clk);
    drive_op(v.op, v.at, v.ao, v.bt, v.bo);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drive_op(4'hF, 4'hF, 4'hF, 4'hF, 4'hF);
    n = 0;
    bcnt = 0;
    while (done !== 1'b1 && n < 40) begin
      if (busy === 1'b1) bcnt++;
      @(negedge clk);
      n++;
    end
    chk({nm, " latency"}, n, v.lat);
    chk({nm, " busy_cycles"}, bcnt, v.lat);
    chk({nm, " busy_at_done"}, busy, 1'b0);
    chk({nm, " res"}, res_val(), v.res);
    chk({nm, " neg"}, neg, v.neg);
    chk({nm, " err"}, err, v.err);
`ifdef CALC_REM_EN
    chk({nm, " rem"}, {rem_tens, rem_ones}, v.rem);
`endif
    @(negedge clk);
    chk({nm, " done_pulse"}, done, 1'b0);
    chk({nm, " res_hold"}, res_val(), v.res);
  endtask

  initial begin
    int ndone;
    int lat;
    logic [15:0] got;

    vecs[0]  = '{OP_ADD, 4'd1, 4'd2, 4'd3, 4'd4, 16'h0046, 1'b0, 1'b0, 8'h00, 16};
    vecs[1]  = '{OP_SUB, 4'd2, 4'd5, 4'd7, 4'd3, 16'h0048, 1'b1, 1'b0, 8'h00, 16};
    vecs[2]  = '{OP_SUB, 4'd7, 4'd3, 4'd2, 4'd5, 16'h0048, 1'b0, 1'b0, 8'h00, 16};
    vecs[3]  = '{OP_SUB, 4'd4, 4'd0, 4'd4, 4'd0, 16'h0000, 1'b0, 1'b0, 8'h00, 16};
    vecs[4]  = '{OP_MUL, 4'd9, 4'd9, 4'd9, 4'd9, 16'h9801, 1'b0, 1'b0, 8'h00, 22};
    vecs[5]  = '{OP_MUL, 4'd0, 4'd0, 4'd5, 4'd7, 16'h0000, 1'b0, 1'b0, 8'h00, 22};
    vecs[6]  = '{OP_DIV, 4'd8, 4'd7, 4'd0, 4'd0, 16'h0000, 1'b0, 1'b1, 8'h00, 1};
    vecs[7]  = '{OP_DIV, 4'd8, 4'd7, 4'd0, 4'd9, 16'h0009, 1'b0, 1'b0, 8'h06, 22};
    vecs[8]  = '{OP_ADD, 4'd1, 4'hB, 4'd2, 4'd3, 16'h0000, 1'b0, 1'b1, 8'h00, 1};
    vecs[9]  = '{4'hE,   4'd1, 4'd1, 4'd2, 4'd3, 16'h0000, 1'b0, 1'b1, 8'h00, 1};
    vecs[10] = '{OP_ADD, 4'd9, 4'd9, 4'd9, 4'd9, 16'h0198, 1'b0, 1'b0, 8'h00, 16};
    vecs[11] = '{OP_DIV, 4'd9, 4'd8, 4'd9, 4'd9, 16'h0000, 1'b0, 1'b0, 8'h98, 22};
    vecs[12] = '{OP_MUL, 4'd0, 4'd5, 4'd1, 4'd3, 16'h0065, 1'b0, 1'b0, 8'h00, 22};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset res", res_val(), 16'h0000);
    chk("reset neg_err", {neg, err}, 2'b00);

    for (int i = 0; i < 13; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // start pulsed again during a multiply is ignored
    @(negedge clk);
    drive_op(OP_MUL, 4'd1, 4'd2, 4'd1, 4'd2);
    start = 1'b1;
    @(negedge clk);
    ndone = 0; lat = 0; got = 16'h0;
    for (int n = 0; n < 40; n++) begin
      if (n == 5) begin
        drive_op(OP_ADD, 4'd1, 4'd1, 4'd1, 4'd1);
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done === 1'b1) begin
        ndone++;
        if (lat == 0) lat = n;
        got = res_val();
      end
      @(negedge clk);
    end
    chk("restart done_count", ndone, 1);
    chk("restart latency", lat, 22);
    chk("restart res", got, 16'h0144);

    // clear in the middle of a multiply
    drive_op(OP_MUL, 4'd9, 4'd9, 4'd9, 4'd9);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int n = 0; n < 30; n++) begin
      clr = (n == 10);
      if (n == 11) begin
        chk("clr busy", busy, 1'b0);
        chk("clr res", res_val(), 16'h0000);
        chk("clr neg_err", {neg, err}, 2'b00);
      end
      if (done === 1'b1) ndone++;
      @(negedge clk);
    end
    clr = 1'b0;
    chk("clr no_done", ndone, 0);

    // clear and start together in IDLE
    drive_op(OP_ADD, 4'd1, 4'd2, 4'd3, 4'd4);
    start = 1'b1;
    clr = 1'b1;
    @(negedge clk);
    start = 1'b0;
    clr = 1'b0;
    chk("clr_start busy", busy, 1'b0);
    ndone = 0;
    for (int n = 0; n < 25; n++) begin
      if (done === 1'b1 || busy === 1'b1) ndone++;
      @(negedge clk);
    end
    chk("clr_start idle", ndone, 0);

    // asynchronous reset during division conversion
    run_vec(vecs[0], "pre_reset");
    drive_op(OP_DIV, 4'd8, 4'd7, 4'd0, 4'd9);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    chk("pre_rst busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst busy", busy, 1'b0);
    chk("async_rst res", res_val(), 16'h0000);
    chk("async_rst flags", {done, neg, err}, 3'b000);
`ifdef CALC_REM_EN
    chk("async_rst rem", {rem_tens, rem_ones}, 8'h00);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    run_vec('{OP_ADD, 4'd0, 4'd5, 4'd0, 4'd5, 16'h0010, 1'b0, 1'b0, 8'h00, 16}, "post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
